// File: rtl/servant_uart_rx.sv
// servant_uart_rx
//   Receive side of the servant serial port. An 8N1 asynchronous line is
//   synchronised, framed by a small bit-timing state machine, and each good
//   byte is pushed into a short FIFO. The CPU drains the FIFO over a
//   single-register-pair Wishbone responder; o_irq is high while data waits.
//
// Ports
//   wb_clk    : clock, every flop updates on the rising edge
//   wb_rst    : synchronous active-high reset
//   i_rx      : asynchronous serial input, idle high
//   i_wb_adr  : register select, 0 = DATA, 1 = STATUS
//   i_wb_dat  : write data, STATUS bit 2 clears overrun, bit 3 clears framing error
//   i_wb_we   : write enable
//   i_wb_cyc  : bus cycle request
//   o_wb_rdt  : registered read data
//   o_wb_ack  : single-cycle acknowledge
//   o_irq     : high while the FIFO holds at least one byte
//
// Register map
//   DATA   read : {23'b0, valid, byte}; reading a valid byte pops it
//   STATUS read : {24'b0, count[3:0], ferr, ovr, full, not_empty}

module servant_uart_rx #(
  parameter int CLKS_PER_BIT = 139,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        i_rx,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_irq
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_t;

  // Synchroniser and edge detector state
  logic       rx_meta;
  logic       rx_s;
  logic       rx_prev;
  logic [1:0] sync_valid;
  logic       start_det;

  // Receiver state
  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             push;
  logic             set_ferr;

  // FIFO and flags
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          empty;
  logic          full;
  logic          ovr;
  logic          ferr;

  // Bus decode
  logic          bus_hit;
  logic          pop;
  logic          push_ok;
  logic          clr_ovr;
  logic          clr_ferr;
  logic [31:0]   rd_data;

  // Two-flop synchroniser on the serial line. sync_valid marks when rx_s holds
  // a genuine sample of the pin rather than its reset value, so rx_prev can
  // only be 1 after the line has really been seen high. That keeps a line
  // stuck low through reset from looking like a start bit.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b0;
      sync_valid <= 2'b00;
    end else begin
      rx_meta    <= i_rx;
      rx_s       <= rx_meta;
      rx_prev    <= sync_valid[1] & rx_s;
      sync_valid <= {sync_valid[0], 1'b1};
    end
  end

  assign start_det = rx_prev & ~rx_s;

  // Receiver state register. Reset drops any byte that is half shifted in.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // Bit timing. The first wait is half a bit so every later sample lands
  // mid-bit. A start bit that is gone at its midpoint is treated as noise.
  // A low stop bit is a framing error; the line is then assumed to be in a
  // break and the receiver waits for it to return high before re-arming.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    set_ferr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_det) begin
          state_n = S_START;
          cnt_n   = HALF_LOAD;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n   = S_DATA;
            cnt_n     = FULL_LOAD;
            bit_idx_n = '0;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          shreg_n   = {rx_s, shreg[7:1]};
          cnt_n     = FULL_LOAD;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            push    = 1'b1;
            state_n = S_IDLE;
          end else begin
            set_ferr = 1'b1;
            state_n  = S_BREAK;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // Bus decode. The acknowledge cycle is the cycle in which a request is seen
  // with no ack outstanding; all reads and side effects are taken there.
  // A pop frees a slot in the same edge, so a push alongside it is accepted
  // even when the FIFO is full.
  always_comb begin
    bus_hit  = i_wb_cyc & ~o_wb_ack;
    pop      = bus_hit & ~i_wb_we & ~i_wb_adr & ~empty;
    push_ok  = push & (~full | pop);
    clr_ovr  = bus_hit & i_wb_we & i_wb_adr & i_wb_dat[2];
    clr_ferr = bus_hit & i_wb_we & i_wb_adr & i_wb_dat[3];
    count_n  = count;
    case ({push_ok, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
    rd_data = '0;
    if (!i_wb_we) begin
      if (i_wb_adr) begin
        rd_data = {24'b0, 4'(count), ferr, ovr, full, ~empty};
      end else if (!empty) begin
        rd_data = {23'b0, 1'b1, mem[rd_ptr]};
      end
    end
  end

  // FIFO storage needs no reset; only slots between the pointers are read.
  always_ff @(posedge wb_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= shreg;
    end
  end

  // FIFO pointers, error flags and the bus outputs. A flag raised by the
  // receiver in the same cycle as a software clear stays set, so no event
  // can be lost to a racing clear.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovr      <= 1'b0;
      ferr     <= 1'b0;
      o_wb_rdt <= '0;
      o_wb_ack <= 1'b0;
      o_irq    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_n;
      ovr      <= (push & full & ~pop) | (ovr & ~clr_ovr);
      ferr     <= set_ferr | (ferr & ~clr_ferr);
      o_wb_ack <= bus_hit;
      if (bus_hit) begin
        o_wb_rdt <= rd_data;
      end
      o_irq    <= (count_n != '0);
    end
  end

endmodule
